// File: rtl/enigma_pkg.sv
// Shared types and constants for the Enigma serial output stage.
// Holds letter width, ASCII codes used by the transmitter and the
// transmitter FSM state encoding.
package enigma_pkg;

    localparam int unsigned LETTER_W    = 5;
    localparam int unsigned LAST_LETTER = 25;

    localparam logic [7:0] ASCII_A     = 8'h41;
    localparam logic [7:0] ASCII_QMARK = 8'h3F;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        SPACE
    } tx_state_t;

endpackage

// File: rtl/enigma_uart_tx_if.sv
// Letter handshake between the Enigma core (master) and the UART
// transmitter (slave).
//   in_valid  : core presents a letter
//   in_ready  : transmitter can accept a letter
//   in_letter : letter index, 0 = 'A'
interface enigma_uart_tx_if;
    import enigma_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [LETTER_W-1:0] in_letter;

    modport master (output in_valid, output in_letter, input in_ready);
    modport slave  (input in_valid, input in_letter, output in_ready);

endinterface

// File: rtl/enigma_bit_timer.sv
// Baud counter for the UART transmitter.
//   clk, rst_n : clock, async active-low reset
//   clear      : restart the bit period (counter back to 0)
//   bit_done   : one-cycle pulse while count = CLKS_PER_BIT-1
// bit_done is registered: it is set one cycle early, when the counter
// sits at CLKS_PER_BIT-2, so it lines up with the final count.
module enigma_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic bit_done
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(CLKS_PER_BIT - 2);

    logic [CNT_W-1:0] cnt;

    // Free-running bit period counter, wraps on its own at the end of a bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            bit_done <= 1'b0;
        end else begin
            if (clear || cnt == CNT_MAX) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            bit_done <= !clear && (cnt == CNT_PRE);
        end
    end

endmodule

// File: rtl/enigma_uart_tx.sv
// Enigma ciphertext UART transmitter: accepts a letter index over a
// valid/ready handshake, maps it to uppercase ASCII ('?' for 26-31) and
// sends it as an 8N1 frame.
//   clk, rst_n : clock, async active-low reset
//   bus        : letter handshake (slave side)
//   tx         : UART line, idle high
//   busy       : frame in progress
// Optional feature macro ENIGMA_TX_GROUP5_EN: after every 5th letter a
// space (0x20) frame is sent, giving classic 5-letter groups.
module enigma_uart_tx
    import enigma_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic             clk,
    input  logic             rst_n,
    enigma_uart_tx_if.slave  bus,
    output logic             tx,
    output logic             busy
);

    tx_state_t   state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  char_q, char_d;
    logic        tx_d;
    logic        in_ready_q;
    logic        timer_clear;
    logic        bit_done;
    logic [2:0]  space_idx;

`ifdef ENIGMA_TX_GROUP5_EN
    logic [2:0]  grp_q, grp_d;
`endif

    function automatic logic [7:0] to_ascii(input logic [LETTER_W-1:0] letter);
        if (letter <= LETTER_W'(LAST_LETTER)) begin
            return ASCII_A + 8'(letter);
        end
        return ASCII_QMARK;
    endfunction

    enigma_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (timer_clear),
        .bit_done (bit_done)
    );

    assign bus.in_ready = in_ready_q;

    // Next state, counters and next line level
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        char_d    = char_q;
        tx_d      = 1'b1;
        space_idx = 3'd0;
`ifdef ENIGMA_TX_GROUP5_EN
        grp_d     = grp_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = START;
                    char_d  = to_ascii(bus.in_letter);
`ifdef ENIGMA_TX_GROUP5_EN
                    grp_d   = (grp_q == 3'd4) ? 3'd0 : grp_q + 3'd1;
`endif
                end
            end
            START: begin
                if (bit_done) state_d = DATA;
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_cnt_q == 4'd7) state_d = STOP;
                    else bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end
            STOP: begin
                if (bit_done) begin
`ifdef ENIGMA_TX_GROUP5_EN
                    // Counter wrapped to 0 on the 5th accepted letter
                    state_d = (grp_q == 3'd0) ? SPACE : IDLE;
`else
                    state_d = IDLE;
`endif
                end
            end
`ifdef ENIGMA_TX_GROUP5_EN
            // Whole space frame in one state: bit_cnt 0 = start, 1-8 data, 9 stop
            SPACE: begin
                if (bit_done) begin
                    if (bit_cnt_q == 4'd9) state_d = IDLE;
                    else bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) bit_cnt_d = 4'd0;

        timer_clear = (state_d != state_q) || (state_q == IDLE);

        // Line level for the coming cycle, so tx can be a plain flop
        case (state_d)
            START: tx_d = 1'b0;
            DATA:  tx_d = char_q[bit_cnt_d[2:0]];
`ifdef ENIGMA_TX_GROUP5_EN
            SPACE: begin
                space_idx = 3'(bit_cnt_d - 4'd1);
                if (bit_cnt_d == 4'd0)      tx_d = 1'b0;
                else if (bit_cnt_d == 4'd9) tx_d = 1'b1;
                else                        tx_d = ASCII_SPACE[space_idx];
            end
`endif
            default: tx_d = 1'b1;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 4'd0;
            char_q     <= 8'd0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            char_q     <= char_d;
            tx         <= tx_d;
            busy       <= (state_d != IDLE);
            in_ready_q <= (state_d == IDLE);
        end
    end

`ifdef ENIGMA_TX_GROUP5_EN
    // Letters accepted modulo 5
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) grp_q <= 3'd0;
        else        grp_q <= grp_d;
    end
`endif

endmodule

// File: tb/tb_enigma_uart_tx.sv
// Self-checking bench for enigma_uart_tx (CLKS_PER_BIT = 4).
// A timing model predicts when letters are accepted, which bytes are sent
// and when each frame starts; a line monitor decodes frames from tx.
module tb_enigma_uart_tx;

    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic tx;
    logic busy;

    enigma_uart_tx_if bus ();

    enigma_uart_tx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave),
        .tx    (tx),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                      tag, obs, obs, exp, exp, $time);
    endtask

    // ---------------- reference model ----------------
    int cyc    = 0;   // index of the last rising edge
    int m_free = 0;   // first edge at which a letter may be accepted
    int m_acc  = 0;   // letters accepted so far
    int m_grp  = 0;
    int exp_q[$];     // expected bytes in line order
    int st_q[$];      // expected start cycle of each frame

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_free = 0;
            m_grp  = 0;
            exp_q.delete();
            st_q.delete();
        end else if (clk) begin
            int l;
            cyc++;
            if (bus.in_valid === 1'b1 && cyc >= m_free) begin
                l = int'(bus.in_letter);
                exp_q.push_back((l <= 25) ? 65 + l : 63);
                st_q.push_back(cyc);
                m_free = cyc + 10 * CPB + 1;
                m_acc++;
                m_grp = (m_grp + 1) % 5;
`ifdef ENIGMA_TX_GROUP5_EN
                if (m_grp == 0) begin
                    exp_q.push_back(32);
                    st_q.push_back(cyc + 10 * CPB);
                    m_free += 10 * CPB;
                end
`endif
            end
        end
    end

    // ---------------- line monitor ----------------
    bit         in_frame = 0;
    int         fcnt;
    bit         fok;
    int         fstart;
    logic [9:0] fbits;
    int         rx_log[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            in_frame = 0;
            check("rst_tx", tx, 1);
            check("rst_busy", busy, 0);
            check("rst_ready", bus.in_ready, 1);
        end else begin
            bit exp_rdy;
            exp_rdy = (cyc + 1 >= m_free);
            check("in_ready", bus.in_ready, exp_rdy);
            check("busy", busy, !exp_rdy);
            if (!in_frame && tx == 1'b0) begin
                in_frame = 1;
                fcnt     = 0;
                fok      = 1;
                fstart   = cyc;
            end
            if (in_frame) begin
                if (fcnt % CPB == 0) fbits[fcnt / CPB] = tx;
                else if (tx !== fbits[fcnt / CPB]) fok = 0;
                fcnt++;
                if (fcnt == 10 * CPB) begin
                    in_frame = 0;
                    check("frame_shape", {fok, fbits[0], fbits[9]}, 3'b101);
                    rx_log.push_back(int'(fbits[8:1]));
                    if (exp_q.size() == 0) begin
                        check("frame_unexpected", fbits[8:1], -1);
                    end else begin
                        check("frame_byte", fbits[8:1], exp_q.pop_front());
                        check("frame_start", fstart, st_q.pop_front());
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input int l);
        int n0;
        int i;
        bus.in_valid  = 1'b1;
        bus.in_letter = 5'(l);
        n0 = m_acc;
        i  = 0;
        while (m_acc == n0 && i < 300) begin
            @(negedge clk);
            i++;
        end
        if (m_acc == n0) check("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        int i;
        i = 0;
        while (!(exp_q.size() == 0 && !in_frame && cyc + 1 >= m_free) && i < 3000) begin
            @(negedge clk);
            i++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [9:0] ebits;
        int bc;
        string grp_str;

        rst_n         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_letter = 5'd0;
        #1 rst_n = 1'b0;

        // Reset with in_valid high: line stays idle
        repeat (3) @(negedge clk);
        check("rst_hold_tx", tx, 1);
        #2 rst_n = 1'b1;

        // Single letter 'A': exact waveform and busy length
        send(0);
        bus.in_valid = 1'b0;
        ebits = {1'b1, 8'h41, 1'b0};
        bc = 0;
        for (int k = 0; k < 45; k++) begin
            if (k < 10 * CPB) check("a_wave", tx, ebits[k / CPB]);
            if (busy) bc++;
            @(negedge clk);
        end
        check("busy_len", bc, 10 * CPB);
        drain();

        // Out-of-range and last letter
        send(31);
        bus.in_valid = 1'b0;
        send(25);
        bus.in_valid = 1'b0;
        drain();

        // Grouping with in_valid held high
        do_reset();
        rx_log.delete();
        for (int l = 0; l < 6; l++) send(l);
        bus.in_valid = 1'b0;
        drain();
`ifdef ENIGMA_TX_GROUP5_EN
        grp_str = "ABCDE F";
`else
        grp_str = "ABCDEF";
`endif
        check("grp_count", rx_log.size(), grp_str.len());
        for (int i = 0; i < grp_str.len() && i < rx_log.size(); i++)
            check("grp_char", rx_log[i], int'(grp_str[i]));

        // Reset during DATA bit 3 of letter 7
        do_reset();
        send(7);
        bus.in_valid = 1'b0;
        repeat (4 * CPB + 1) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_tx", tx, 1);
        check("midrst_busy", busy, 0);
        check("midrst_ready", bus.in_ready, 1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        rx_log.delete();
        send(2);
        bus.in_valid = 1'b0;
        drain();
        check("post_rst_byte", rx_log.size() > 0 ? rx_log[0] : -1, 8'h43);
        for (int l = 1; l < 5; l++) send(l);
        bus.in_valid = 1'b0;
        drain();
`ifdef ENIGMA_TX_GROUP5_EN
        check("post_rst_group", rx_log.size(), 6);
        check("post_rst_space", rx_log.size() > 0 ? rx_log[rx_log.size() - 1] : -1, 32);
`else
        check("post_rst_group", rx_log.size(), 5);
`endif

        // Busy isolation: input noise during a frame
        for (int r = 0; r < 3; r++) begin
            send(int'($urandom_range(0, 31)));
            for (int k = 0; k < 9 * CPB; k++) begin
                bus.in_valid  = 1'(($urandom) % 2);
                bus.in_letter = 5'($urandom);
                @(negedge clk);
            end
            bus.in_valid = 1'b0;
            drain();
        end

        // Random letters with random gaps
        for (int r = 0; r < 20; r++) begin
            send(int'($urandom_range(0, 31)));
            if ($urandom % 2) bus.in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        bus.in_valid = 1'b0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/enigma_uart_tx.md
# enigma_uart_tx

Serial output stage downstream of the Enigma core. It takes each enciphered letter index (0–25) from the core over a valid/ready handshake, maps it to uppercase ASCII, and transmits it as an 8N1 UART frame on a single pin. In the top level this pin drives one spare `uio_out` bit, so ciphertext can be read on a plain serial terminal.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 434: clock cycles per UART bit (50 MHz / 115200). Must be ≥ 2.

Ports:
- `clk`, input, 1: the single clock.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `in_valid`, input, 1: core presents a letter.
- `in_ready`, output, 1: block can accept a letter. High only in IDLE.
- `in_letter`, input, 5: letter index; 0 = 'A'.
- `tx`, output, 1: UART line, idle high.
- `busy`, output, 1: a frame is in progress (state ≠ IDLE).

## Operation

- Transfer occurs on a rising edge where `in_valid && in_ready`. The character is latched internally at that edge.
  - `in_letter` ≤ 25 maps to 0x41 + letter.
  - `in_letter` 26–31 maps to 0x3F ('?').
- Frame is 8N1: start bit (0), 8 data bits LSB first, stop bit (1).
- FSM states:
  - IDLE → START on transfer.
  - START → DATA after one bit time.
  - DATA → STOP after 8 bit times.
  - STOP → IDLE after one bit time (or → SPACE, see Configuration).
- A bit counter (0..7) and a baud counter (0..CLKS_PER_BIT−1) both clear on every state entry.
- `in_valid` is ignored while busy. Changes to `in_letter` during a frame do not affect it.
- Reset values: `tx`=1, `busy`=0, `in_ready`=1, FSM=IDLE, all counters 0, group counter 0.
- Reset asserted mid-frame aborts the frame immediately. `tx` returns to 1 asynchronously. No partial frame resumes after reset.

## Timing

- Accept at edge T. `tx` falls at T+1; `tx` is registered and never comes from combinational logic.
- Each bit is held exactly `CLKS_PER_BIT` cycles. A frame spans cycles T+1 … T+10·CLKS_PER_BIT.
- IDLE is re-entered at T+1+10·CLKS_PER_BIT, and `in_ready` is high in that cycle.
  - With `in_valid` held high, back-to-back frames are separated by exactly one extra idle-high cycle.
  - The effective stop bit is therefore CLKS_PER_BIT+1 cycles.
- `in_ready` and `busy` are decoded from registered state only. There is no combinational path from `in_valid` to `in_ready`.

## Configuration

- Macro: `ENIGMA_TX_GROUP5_EN`.
- **Defined:** a mod-5 letter counter increments on each accepted letter.
  - After the stop bit of every 5th letter, the FSM enters SPACE and sends one 0x20 frame with the same timing, then returns to IDLE.
  - `in_ready` stays low throughout SPACE.
  - The counter clears on reset. This gives classic 5-letter groups.
- **Undefined:** no SPACE state, no group counter; STOP always → IDLE.

## Structure

- Package `enigma_pkg` holds:
  - `LETTER_W` = 5
  - `ASCII_A` = 8'h41
  - `ASCII_QMARK` = 8'h3F
  - `ASCII_SPACE` = 8'h20
  - the `tx_state_t` enum (IDLE, START, DATA, STOP, SPACE).
- One sub-module is natural: `enigma_bit_timer`.
  - Parameterised baud counter of width `$clog2(CLKS_PER_BIT)`.
  - Input: clear. Output: a one-cycle `bit_done` pulse on count = CLKS_PER_BIT−1.
- The ASCII mapping and the FSM stay in `enigma_uart_tx`.

## Test plan

All scenarios use CLKS_PER_BIT = 4.

1. **Reset values:** assert `rst_n`=0 with `in_valid`=1 → `tx`=1, `busy`=0, `in_ready`=1; no frame starts until after release.
2. **Single letter:** `in_letter`=0 accepted at T → `tx` shows 0 | 1,0,0,0,0,0,1,0 | 1, each bit 4 cycles, starting T+1. `busy` is high for 40 cycles. `in_ready` returns high at T+41.
3. **Out-of-range index:** `in_letter`=31 → data bits decode to 0x3F. `in_letter`=25 → 0x5A.
4. **Grouping:** `in_valid` held high with letters 0,1,2,3,4,5.
   - With `ENIGMA_TX_GROUP5_EN`: 7 frames, decoded "ABCDE F", and `in_ready` is low during the 0x20 frame.
   - Without it: 6 frames, "ABCDEF", with 1-cycle gaps.
5. **Reset mid-frame:** reset pulsed during the DATA bit 3 of letter 7 → `tx`=1 within the reset cycle. After release, letter 2 is sent cleanly as 0x43, and the group counter restarts at 0.
6. **Busy isolation:** during a frame, toggle `in_valid` and change `in_letter` every cycle → no extra transfers occur, and the transmitted byte equals the latched value.
